// File: rtl/wt_dm_cache_pkg.sv
// Shared types and address-field helpers for the write-through direct-mapped cache.
// Field widths are derived from the LINES / WORDS_PER_LINE parameters.
package wt_dm_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_WAIT = 3'd3,
        ST_WRITE_REQ   = 3'd4,
        ST_WRITE_WAIT  = 3'd5,
        ST_RESP        = 3'd6
    } cache_state_e;

    // Number of address bits needed to select one of n items (n a power of two).
    function automatic int log2_of(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Storage width for a field; a zero-bit field is carried as one bit tied to 0.
    function automatic int field_w(input int n);
        return (log2_of(n) == 0) ? 1 : log2_of(n);
    endfunction

    function automatic int tag_w(input int lines, input int words_per_line);
        return 32 - 2 - log2_of(words_per_line) - log2_of(lines);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wt_dm_cache_line_store.sv
// Tag array, valid vector with single-cycle clear, and word data array with byte writes.
// Tag and data arrays carry no reset; only the valid bits are reset.
module cache_line_store
    import wt_dm_cache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int IW             = 6,
    parameter int WW             = 2,
    parameter int TW             = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_all,
    input  logic [IW-1:0] index,
    input  logic [WW-1:0] rd_word,
    output logic [TW-1:0] rd_tag,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    input  logic          line_we,
    input  logic [TW-1:0] line_tag,
    input  logic          line_valid,
    input  logic          wr_en,
    input  logic [WW-1:0] wr_word,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data
);

    localparam int DEPTH = LINES * WORDS_PER_LINE;
    localparam int AW    = log2_of(DEPTH);

    logic [LINES-1:0] valid_r;
    logic [TW-1:0]    tag_r  [LINES];
    logic [31:0]      data_r [DEPTH];
    logic [AW-1:0]    rd_addr_s;
    logic [AW-1:0]    wr_addr_s;

    function automatic logic [AW-1:0] word_addr(input logic [IW-1:0] idx,
                                                input logic [WW-1:0] wrd);
        return AW'(int'(idx) * WORDS_PER_LINE + int'(wrd));
    endfunction

    // Read path and flat word addresses
    always_comb begin
        rd_addr_s = word_addr(index, rd_word);
        wr_addr_s = word_addr(index, wr_word);
        rd_tag    = tag_r[index];
        rd_valid  = valid_r[index];
        rd_data   = data_r[rd_addr_s];
    end

    // Valid bits: flush clears every line in one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else if (clear_all) begin
            valid_r <= '0;
        end else if (line_we) begin
            valid_r[index] <= line_valid;
        end
    end

    // Tag array
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_r[index] <= line_tag;
        end
    end

    // Data array with per-byte write enable
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_addr_s] <= byte_merge(data_r[wr_addr_s], wr_data, wr_be);
        end
    end

endmodule

// File: rtl/wt_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one request in flight.
// Refills fetch a whole line word by word; writes always go through to memory.
module wt_dm_cache
    import wt_dm_cache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic        core_we_i,
    input  logic        core_req_i,
    input  logic [3:0]  core_be_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic        core_error_o,
    output logic [31:0] core_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_error_i,
    input  logic        flush_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    localparam int WB = log2_of(WORDS_PER_LINE);
    localparam int IB = log2_of(LINES);
    localparam int WW = field_w(WORDS_PER_LINE);
    localparam int IW = field_w(LINES);
    localparam int TW = tag_w(LINES, WORDS_PER_LINE);

    cache_state_e state_r, state_s;

    logic [31:0]   addr_r, wdata_r, resp_data_r;
    logic          we_r, err_r, err_s, flush_pend_r;
    logic [3:0]    be_r;
    logic [WW-1:0] cnt_r, cnt_s;

    logic [IW-1:0] index_s;
    logic [WW-1:0] word_s, wr_word_s;
    logic [TW-1:0] tag_s, rd_tag_s;
    logic [31:0]   line_base_s, rd_data_s, rdata_s, wr_data_s;
    logic          rd_valid_s, hit_s, rerr_s, gnt_s, clear_s, resp_cap_s;
    logic          wr_en_s, line_we_s, line_valid_s, hit_inc_s, miss_inc_s;
    logic [3:0]    wr_be_s;

    logic          mem_req_s, mem_we_s;
    logic [3:0]    mem_be_s;
    logic [31:0]   mem_addr_s, mem_wdata_s;

    // Address decomposition of the latched request
    always_comb begin
        word_s      = WW'((addr_r >> 2) & 32'(WORDS_PER_LINE - 1));
        index_s     = IW'(addr_r >> (2 + WB));
        tag_s       = TW'(addr_r >> (2 + WB + IB));
        line_base_s = addr_r & ~32'(WORDS_PER_LINE * 4 - 1);
        hit_s       = rd_valid_s && (rd_tag_s == tag_s);
    end

    cache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IW             (IW),
        .WW             (WW),
        .TW             (TW)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .clear_all  (clear_s),
        .index      (index_s),
        .rd_word    (word_s),
        .rd_tag     (rd_tag_s),
        .rd_valid   (rd_valid_s),
        .rd_data    (rd_data_s),
        .line_we    (line_we_s),
        .line_tag   (tag_s),
        .line_valid (line_valid_s),
        .wr_en      (wr_en_s),
        .wr_word    (wr_word_s),
        .wr_be      (wr_be_s),
        .wr_data    (wr_data_s)
    );

    // Next-state, store control and response values
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        err_s        = err_r;
        rdata_s      = 32'h0000_0000;
        rerr_s       = 1'b0;
        gnt_s        = 1'b0;
        clear_s      = 1'b0;
        resp_cap_s   = 1'b0;
        wr_en_s      = 1'b0;
        wr_be_s      = 4'h0;
        wr_data_s    = 32'h0000_0000;
        wr_word_s    = word_s;
        line_we_s    = 1'b0;
        line_valid_s = 1'b0;
        hit_inc_s    = 1'b0;
        miss_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_i || flush_pend_r) begin
                    clear_s = 1'b1;
                end else if (core_req_i) begin
                    gnt_s   = 1'b1;
                    state_s = ST_LOOKUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (we_r) begin
                    wr_en_s   = hit_s;
                    wr_be_s   = be_r;
                    wr_data_s = wdata_r;
                    state_s   = ST_WRITE_REQ;
                end else if (hit_s) begin
                    hit_inc_s = 1'b1;
                    rdata_s   = rd_data_s;
                    state_s   = ST_RESP;
                end else begin
                    // Invalidate up front: the line's words get overwritten during refill
                    miss_inc_s = 1'b1;
                    line_we_s  = 1'b1;
                    cnt_s      = '0;
                    err_s      = 1'b0;
                    state_s    = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                if (mem_gnt_i) begin
                    state_s = ST_REFILL_WAIT;
                end else begin
                    state_s = ST_REFILL_REQ;
                end
            end
            ST_REFILL_WAIT: begin
                if (mem_rvalid_i) begin
                    wr_en_s    = 1'b1;
                    wr_be_s    = 4'hF;
                    wr_data_s  = mem_rdata_i;
                    wr_word_s  = cnt_r;
                    err_s      = err_r | mem_error_i;
                    resp_cap_s = (cnt_r == word_s);
                    if (cnt_r == WW'(WORDS_PER_LINE - 1)) begin
                        line_we_s    = 1'b1;
                        line_valid_s = ~err_s;
                        rdata_s      = (cnt_r == word_s) ? mem_rdata_i : resp_data_r;
                        rerr_s       = err_s;
                        state_s      = ST_RESP;
                    end else begin
                        cnt_s   = cnt_r + WW'(1);
                        state_s = ST_REFILL_REQ;
                    end
                end else begin
                    state_s = ST_REFILL_WAIT;
                end
            end
            ST_WRITE_REQ: begin
                if (mem_gnt_i) begin
                    state_s = ST_WRITE_WAIT;
                end else begin
                    state_s = ST_WRITE_REQ;
                end
            end
            ST_WRITE_WAIT: begin
                if (mem_rvalid_i) begin
                    rerr_s  = mem_error_i;
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WRITE_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Memory-side values for the cycle being entered
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_be_s    = 4'h0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        case (state_s)
            ST_REFILL_REQ: begin
                mem_req_s  = 1'b1;
                mem_be_s   = 4'hF;
                mem_addr_s = line_base_s | (32'(cnt_s) << 2);
            end
            ST_WRITE_REQ: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_be_s    = be_r;
                mem_addr_s  = {addr_r[31:2], 2'b00};
                mem_wdata_s = wdata_r;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    assign core_gnt_o = gnt_s & ~reset;

    // Control state, request latch, flush pending and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            we_r         <= 1'b0;
            be_r         <= 4'h0;
            cnt_r        <= '0;
            err_r        <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            flush_pend_r <= 1'b0;
            hit_count_o  <= 32'h0000_0000;
            miss_count_o <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            if (gnt_s) begin
                addr_r  <= core_addr_i;
                wdata_r <= core_wdata_i;
                we_r    <= core_we_i;
                be_r    <= core_be_i;
            end
            if (resp_cap_s) begin
                resp_data_r <= mem_rdata_i;
            end
            if (clear_s) begin
                flush_pend_r <= 1'b0;
            end else if (flush_i) begin
                flush_pend_r <= 1'b1;
            end
            if (hit_inc_s && (hit_count_o != 32'hFFFF_FFFF)) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if (miss_inc_s && (miss_count_o != 32'hFFFF_FFFF)) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end

    // Registered core and memory outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid_o <= 1'b0;
            core_rdata_o  <= 32'h0000_0000;
            core_error_o  <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= 4'h0;
            mem_addr_o    <= 32'h0000_0000;
            mem_wdata_o   <= 32'h0000_0000;
        end else begin
            core_rvalid_o <= (state_s == ST_RESP);
            core_rdata_o  <= rdata_s;
            core_error_o  <= rerr_s;
            mem_req_o     <= mem_req_s;
            mem_we_o      <= mem_we_s;
            mem_be_o      <= mem_be_s;
            mem_addr_o    <= mem_addr_s;
            mem_wdata_o   <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_wt_dm_cache.sv
// Directed bench for wt_dm_cache: a behavioural memory answers requests, and each
// scenario task checks the core response, memory traffic and counters inline.
module tb_wt_dm_cache;

    logic        clk, reset;
    logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
    logic        core_we_i, core_req_i, core_gnt_o, core_rvalid_o, core_error_o;
    logic [3:0]  core_be_i, mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_we_o, mem_req_o, mem_gnt_i, mem_rvalid_i, mem_error_i;
    logic        flush_i;
    logic [31:0] hit_count_o, miss_count_o;

    wt_dm_cache dut (
        .clk(clk), .reset(reset),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_we_i(core_we_i), .core_req_i(core_req_i), .core_be_i(core_be_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_error_o(core_error_o), .core_rdata_o(core_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_req_o(mem_req_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_error_i(mem_error_i),
        .flush_i(flush_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Memory model state and traffic log
    int          gnt_delay = 0;
    int          wait_cnt = 0;
    int          stall_cycles = 0;
    int          req_cycles = 0;
    bit          addr_moved = 0;
    bit          err_en = 0;
    logic [31:0] err_addr = 32'h0;
    bit          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        pend_we = 1'b0;
    logic [31:0] first_addr = 32'h0;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wdata[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: grant after gnt_delay stalled cycles, rvalid the cycle after grant
    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_error_i = 1'b0; mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_error_i = 1'b0; mem_rdata_i = 32'h0;
            if (reset) begin
                pend = 0;
                wait_cnt = 0;
            end else if (pend) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_we ? 32'h0 : (32'hD000_0000 + pend_addr);
                mem_error_i  = err_en && (pend_addr == err_addr);
                pend = 0;
            end else if (mem_req_o) begin
                req_cycles++;
                if (wait_cnt == 0) first_addr = mem_addr_o;
                else if (mem_addr_o !== first_addr) addr_moved = 1;
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                    stall_cycles++;
                end else begin
                    mem_gnt_i = 1'b1;
                    wait_cnt = 0;
                    pend = 1;
                    pend_addr = mem_addr_o;
                    pend_we = mem_we_o;
                    log_addr.push_back(mem_addr_o);
                    log_we.push_back(mem_we_o);
                    log_be.push_back(mem_be_o);
                    log_wdata.push_back(mem_wdata_o);
                end
            end
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
        stall_cycles = 0; addr_moved = 0;
    endtask

    // One core transaction; lat = cycles from grant cycle to rvalid cycle
    task automatic core_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata,
                            output logic err, output int lat, output bit ok);
        int n;
        int c0;
        ok = 1; lat = 0; rdata = 32'h0; err = 1'b0;
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = we; core_addr_i = addr;
        core_wdata_i = wdata; core_be_i = be;
        #1;
        n = 0;
        while (!core_gnt_o && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!core_gnt_o) begin
            ok = 0; core_req_i = 1'b0;
            return;
        end
        c0 = cyc;
        @(negedge clk);
        core_req_i = 1'b0; core_we_i = 1'b0;
        n = 0;
        while (!core_rvalid_o && n < 200) begin
            @(negedge clk); n++;
        end
        if (!core_rvalid_o) ok = 0;
        else begin
            lat = cyc - c0; rdata = core_rdata_o; err = core_error_o;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        core_req_i = 1'b1;
        #1;
        tests_run++;
        if ({core_gnt_o, core_rvalid_o, core_error_o, mem_req_o, mem_we_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {core_gnt_o, core_rvalid_o, core_error_o, mem_req_o, mem_we_o});
        end
        tests_run++;
        if ({core_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 100'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h be %h want 0",
                     core_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
        end
        tests_run++;
        if (hit_count_o !== 32'h0 || miss_count_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_counters: hit %0d miss %0d want 0 0", hit_count_o, miss_count_o);
        end
        core_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; logic er; int lat; bit ok;
        clear_log();
        core_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL cold_timeout: ok %0d want 1", ok); end
        tests_run++;
        if (log_addr.size() !== 4) begin
            tests_failed++; $display("FAIL cold_nreads: got %0d want 4", log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (log_addr[i] !== 32'h100 + 32'(i * 4) || log_we[i] !== 1'b0 || log_be[i] !== 4'hF) begin
                    tests_failed++;
                    $display("FAIL cold_mem%0d: addr %h we %b be %h want %h 0 f",
                             i, log_addr[i], log_we[i], log_be[i], 32'h100 + 32'(i * 4));
                end
            end
        end
        tests_run++;
        if (rd !== 32'hD000_0100 || er !== 1'b0) begin
            tests_failed++; $display("FAIL cold_rdata: got %h err %b want d0000100 0", rd, er);
        end
        tests_run++;
        if (miss_count_o !== 32'd1 || hit_count_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL cold_counters: hit %0d miss %0d want 0 1", hit_count_o, miss_count_o);
        end
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; logic er; int lat; bit ok; int rc0;
        rc0 = req_cycles;
        core_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (!ok || lat !== 2) begin
            tests_failed++; $display("FAIL hit_latency: ok %0d lat %0d want 1 2", ok, lat);
        end
        tests_run++;
        if (rd !== 32'hD000_0104) begin
            tests_failed++; $display("FAIL hit_rdata: got %h want d0000104", rd);
        end
        @(negedge clk);
        tests_run++;
        if (core_rvalid_o !== 1'b0) begin
            tests_failed++; $display("FAIL hit_rvalid_pulse: got %b want 0", core_rvalid_o);
        end
        tests_run++;
        if (req_cycles !== rc0 || hit_count_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL hit_nomem: req cycles %0d hit %0d want %0d 1", req_cycles, hit_count_o, rc0);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; logic er; int lat; bit ok; int rc0;
        clear_log();
        core_txn(1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'b0101, rd, er, lat, ok);
        tests_run++;
        if (!ok || er !== 1'b0 || log_addr.size() !== 1) begin
            tests_failed++;
            $display("FAIL write_resp: ok %0d err %b nmem %0d want 1 0 1", ok, er, log_addr.size());
        end else begin
            tests_run++;
            if (log_addr[0] !== 32'h104 || log_we[0] !== 1'b1 || log_be[0] !== 4'b0101 ||
                log_wdata[0] !== 32'hAABB_CCDD) begin
                tests_failed++;
                $display("FAIL write_mem: addr %h we %b be %b wdata %h want 104 1 0101 aabbccdd",
                         log_addr[0], log_we[0], log_be[0], log_wdata[0]);
            end
        end
        rc0 = req_cycles;
        core_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (rd !== 32'hD0BB_01DD || req_cycles !== rc0 || lat !== 2) begin
            tests_failed++;
            $display("FAIL write_merge: got %h lat %0d memreq %0d want d0bb01dd 2 %0d",
                     rd, lat, req_cycles, rc0);
        end
        tests_run++;
        if (hit_count_o !== 32'd2 || miss_count_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL write_counters: hit %0d miss %0d want 2 1", hit_count_o, miss_count_o);
        end
    endtask

    task automatic test_error_delay();
        logic [31:0] rd; logic er; int lat; bit ok;
        clear_log();
        gnt_delay = 5; err_en = 1; err_addr = 32'h0000_0148;
        core_txn(1'b0, 32'h0000_0140, 32'h0, 4'h0, rd, er, lat, ok);
        gnt_delay = 0; err_en = 0;
        tests_run++;
        if (!ok || stall_cycles !== 20 || addr_moved !== 1'b0) begin
            tests_failed++;
            $display("FAIL delay_stall: ok %0d stalls %0d moved %0d want 1 20 0", ok, stall_cycles, addr_moved);
        end
        tests_run++;
        if (log_addr.size() !== 4 || log_addr[0] !== 32'h140 || log_addr[3] !== 32'h14C) begin
            tests_failed++;
            $display("FAIL err_allwords: n %0d first %h last %h want 4 140 14c",
                     log_addr.size(), log_addr[0], log_addr[log_addr.size() - 1]);
        end
        tests_run++;
        if (er !== 1'b1) begin
            tests_failed++; $display("FAIL err_flag: got %b want 1", er);
        end
        core_txn(1'b0, 32'h0000_0140, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (miss_count_o !== 32'd3 || rd !== 32'hD000_0140 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_remiss: miss %0d rdata %h err %b want 3 d0000140 0", miss_count_o, rd, er);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic er; int lat; bit ok;
        @(negedge clk);
        flush_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_0100;
        #1;
        tests_run++;
        if (core_gnt_o !== 1'b0) begin
            tests_failed++; $display("FAIL flush_nognt: got %b want 0", core_gnt_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        tests_run++;
        if (core_gnt_o !== 1'b1) begin
            tests_failed++; $display("FAIL flush_gnt_after: got %b want 1", core_gnt_o);
        end
        core_req_i = 1'b0;
        core_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (miss_count_o !== 32'd4 || rd !== 32'hD000_0100) begin
            tests_failed++;
            $display("FAIL flush_miss: miss %0d rdata %h want 4 d0000100", miss_count_o, rd);
        end
        // Flush pulsed mid-refill must drop the line being refilled
        fork
            core_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, er, lat, ok);
            begin
                repeat (4) @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        join
        core_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (miss_count_o !== 32'd6 || hit_count_o !== 32'd2 || rd !== 32'hD000_0200) begin
            tests_failed++;
            $display("FAIL flush_busy: miss %0d hit %0d rdata %h want 6 2 d0000200",
                     miss_count_o, hit_count_o, rd);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; logic er; int lat; bit ok; int n;
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_0100;
        @(negedge clk);
        core_req_i = 1'b0;
        n = 0;
        while (!mem_gnt_i && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (!mem_gnt_i) begin tests_failed++; $display("FAIL midrst_gnt: got 0 want 1"); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mem_req_o, core_rvalid_o, core_error_o, core_gnt_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
            miss_count_o !== 32'h0 || hit_count_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: req %b rvalid %b addr %h miss %0d hit %0d want 0 0 0 0 0",
                     mem_req_o, core_rvalid_o, mem_addr_o, miss_count_o, hit_count_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
        core_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, rd, er, lat, ok);
        tests_run++;
        if (!ok || miss_count_o !== 32'd1 || log_addr.size() !== 4 || rd !== 32'hD000_0100) begin
            tests_failed++;
            $display("FAIL midrst_remiss: ok %0d miss %0d nmem %0d rdata %h want 1 1 4 d0000100",
                     ok, miss_count_o, log_addr.size(), rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        core_addr_i = 32'h0; core_wdata_i = 32'h0; core_we_i = 1'b0;
        core_req_i = 1'b0; core_be_i = 4'h0; flush_i = 1'b0;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_error_delay();
        test_flush();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
